riscv_regfile_arbiter: RTL and testbench
========================================

# riscv_regfile_arbiter

Shares the single-ported-per-cycle `riscv_registers` array between the core pipeline and the debug module. Each cycle it grants at most one requester, drives the register file's `cs/ra/rb/rd/wen/data` combinationally, and returns read data with one-cycle latency. It also enforces x0 write suppression and debug starvation bounds, and supports a debug lock that excludes the core.

## Interface
- `DBG_MAX_WAIT`, default 8: maximum consecutive cycles a pending debug request may lose to the core before it is forcibly granted (range 1..255).
- `clk  in  1`: clock; all state updates on the rising edge.
- `rstn  in  1`: asynchronous active-low reset.
- `core_req  in  1`: core access request.
- `core_ready  out  1`: core granted this cycle; the transfer happens when `core_req & core_ready`.
- `core_ra, core_rb, core_rd  in  5 each`: core source and destination indices.
- `core_wen  in  1`: core writes `core_wdata` to `core_rd`.
- `core_wdata  in  32`: core write data.
- `core_rsp_valid  out  1`: `core_a`/`core_b` are valid.
- `core_a, core_b  out  32`: core read data.
- `dbg_req  in  1`: debug access request.
- `dbg_ready  out  1`: debug granted this cycle.
- `dbg_addr  in  5`: debug register index.
- `dbg_wen  in  1`: debug write.
- `dbg_wdata  in  32`: debug write data.
- `dbg_lock  in  1`: hold exclusive ownership after a debug grant.
- `dbg_rsp_valid  out  1`: `dbg_rdata` is valid.
- `dbg_rdata  out  32`: debug read data.
- `rf_cs, rf_wen  out  1 each`: register file select and write enable.
- `rf_ra, rf_rb, rf_rd  out  5 each`: register file indices.
- `rf_data  out  32`: register file write data.
- `rf_a, rf_b  in  32 each`: register file read outputs, registered inside the register file.

## Operation
- FSM states:
  - `SHARED` (reset state).
  - `DBG_LOCKED`.
- Grant in `SHARED`:
  - The core wins by default.
  - The debug requester wins if `core_req==0`, or if `wait_cnt >= DBG_MAX_WAIT`.
- `wait_cnt` (8-bit):
  - Increments while `dbg_req & ~dbg_ready`, saturating at 255.
  - Clears on a debug grant or when `dbg_req==0`.
- Lock entry: on a debug grant with `dbg_lock==1`, go to `DBG_LOCKED`.
- In `DBG_LOCKED`:
  - `core_ready=0`.
  - `dbg_ready=dbg_req`.
  - Return to `SHARED` on the first cycle `dbg_lock==0`. That cycle is arbitrated as `SHARED`.
- `core_ready` and `dbg_ready` are never both 1.
- A ready signal may assert without its request; it carries no meaning then.
- Core grant drives:
  - `rf_cs=1`.
  - `rf_ra=core_ra`, `rf_rb=core_rb`, `rf_rd=core_rd`.
  - `rf_data=core_wdata`.
  - `rf_wen=core_wen & (core_rd!=0)`.
- Debug grant drives:
  - `rf_cs=1`.
  - `rf_ra=dbg_addr`, `rf_rb=0`, `rf_rd=dbg_addr`.
  - `rf_data=dbg_wdata`.
  - `rf_wen=dbg_wen & (dbg_addr!=0)`.
- No grant: `rf_cs=0`, `rf_wen=0`, and all index and data outputs are 0.
- Writes to x0 are always dropped. The register file does not hardwire x0; this block does.
- Responses are produced for every grant, reads and writes alike:
  - The `owner` register records which requester was granted.
  - The following cycle asserts `core_rsp_valid` or `dbg_rsp_valid` for exactly one cycle.
  - Data comes straight from `rf_a` (`core_a`, `dbg_rdata`) and `rf_b` (`core_b`).
- Read-during-write: a read of the index being written in the same grant returns the OLD value.
- Same-requester back-to-back grants are legal every cycle. Throughput is 1 access/cycle.

## Timing
- Reset (async assert, sync-to-clk deassert by system):
  - State `SHARED`.
  - `wait_cnt=0`.
  - `core_rsp_valid=0`, `dbg_rsp_valid=0`.
  - `owner` cleared.
  - `core_ready`, `dbg_ready`, `rf_cs` and `rf_wen` are forced 0 while `rstn==0`.
- Grant-to-response latency is exactly 1 cycle: grant at edge N issues, response is valid between edges N+1 and N+2.
- Readies and `rf_*` outputs are combinational from the requests, `wait_cnt` and the state.
- Response valid flags are registered.
- Reset mid-operation:
  - A pending response is discarded; no valid pulse is produced after reset.
  - An in-flight lock is released.
- Simultaneous requests with `wait_cnt == DBG_MAX_WAIT-1` at edge: the core wins this cycle and `wait_cnt` reaches `DBG_MAX_WAIT`. Debug wins the next cycle.
- Dropping `dbg_req` while in `DBG_LOCKED` with `dbg_lock==1` stays locked; the core remains blocked.

## Test plan
- Core write then read:
  - Stimulus: core writes x5=0xDEADBEEF; next cycle reads ra=5, rb=0.
  - Response: `core_rsp_valid` pulses after each grant; the second response gives `core_a=0xDEADBEEF`, `core_b=0`.
- x0 protection:
  - Stimulus: core and debug each write 0x12345678 to index 0; then a debug read of addr 0.
  - Response: `rf_wen` stays 0 for both writes; `dbg_rdata=0`.
- Starvation bound (`DBG_MAX_WAIT=8`):
  - Stimulus: `core_req` held high, `dbg_req` asserted at cycle 0.
  - Response: `dbg_ready` first asserts in cycle 8; `core_ready=0` in that cycle only; `dbg_rsp_valid` at cycle 9.
- Debug lock:
  - Stimulus: debug granted with `dbg_lock=1`, `core_req` high for 5 cycles, then `dbg_lock` falls.
  - Response: `core_ready=0` throughout the lock; the core is granted in the cycle `dbg_lock==0`.
- Read-during-write:
  - Stimulus: x7=1; core issues ra=7, rd=7, wen, wdata=2.
  - Response: `core_a=1`; a following read returns 2.
- Async reset mid-lock with a pending response.
  - Response: all valids and readies drop immediately; after reset, `SHARED` state and the core is granted on its first request.

Source files
------------

// File: rtl/riscv_regfile_arbiter.sv
// Arbiter sharing one riscv_registers access port between the core pipeline and the debug module.
// Grants at most one requester per cycle, suppresses x0 writes, bounds debug starvation, supports a debug lock.
module riscv_regfile_arbiter #(
    parameter int unsigned DBG_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rstn,
    // Handshake: a transfer happens on a rising edge where req & ready; ready is combinational
    // and may assert without req (meaningless then); each transfer yields exactly one response
    // pulse on the following cycle, for reads and writes alike.
    input  logic        core_req,
    output logic        core_ready,
    input  logic [4:0]  core_ra,
    input  logic [4:0]  core_rb,
    input  logic [4:0]  core_rd,
    input  logic        core_wen,
    input  logic [31:0] core_wdata,
    output logic        core_rsp_valid,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        dbg_req,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_addr,
    input  logic        dbg_wen,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_lock,
    output logic        dbg_rsp_valid,
    output logic [31:0] dbg_rdata,
    output logic        rf_cs,
    output logic        rf_wen,
    output logic [4:0]  rf_ra,
    output logic [4:0]  rf_rb,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    input  logic [31:0] rf_a,
    input  logic [31:0] rf_b,
    output logic        arb_state
);

    typedef enum logic {SHARED = 1'b0, DBG_LOCKED = 1'b1} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CORE = 2'd1, OWN_DBG = 2'd2} owner_e;

    localparam logic [7:0] MAX_WAIT = 8'(DBG_MAX_WAIT);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       core_xfer, dbg_xfer;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= SHARED;
            owner_q    <= OWN_NONE;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        core_ready = 1'b0;
        dbg_ready  = 1'b0;
        // The cycle dbg_lock falls is arbitrated as if already shared.
        if (!rstn) begin
            core_ready = 1'b0;
        end else if (state_q == DBG_LOCKED && dbg_lock) begin
            dbg_ready = dbg_req;
        end else if (dbg_req && (!core_req || wait_cnt_q >= MAX_WAIT)) begin
            dbg_ready = 1'b1;
        end else begin
            core_ready = 1'b1;
        end
    end

    assign core_xfer = core_req & core_ready;
    assign dbg_xfer  = dbg_req & dbg_ready;

    always_comb begin
        rf_cs   = 1'b0;
        rf_wen  = 1'b0;
        rf_ra   = 5'd0;
        rf_rb   = 5'd0;
        rf_rd   = 5'd0;
        rf_data = 32'd0;
        // The register file does not hardwire x0, so writes to index 0 are dropped here.
        if (core_xfer) begin
            rf_cs   = 1'b1;
            rf_wen  = core_wen & (core_rd != 5'd0);
            rf_ra   = core_ra;
            rf_rb   = core_rb;
            rf_rd   = core_rd;
            rf_data = core_wdata;
        end else if (dbg_xfer) begin
            rf_cs   = 1'b1;
            rf_wen  = dbg_wen & (dbg_addr != 5'd0);
            rf_ra   = dbg_addr;
            rf_rd   = dbg_addr;
            rf_data = dbg_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = OWN_NONE;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            SHARED:     if (dbg_xfer && dbg_lock) state_d = DBG_LOCKED;
            DBG_LOCKED: if (!dbg_lock) state_d = SHARED;
            default:    state_d = SHARED;
        endcase
        if (core_xfer)     owner_d = OWN_CORE;
        else if (dbg_xfer) owner_d = OWN_DBG;
        if (!dbg_req || dbg_ready)    wait_cnt_d = 8'd0;
        else if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
    end

    assign core_rsp_valid = (owner_q == OWN_CORE);
    assign dbg_rsp_valid  = (owner_q == OWN_DBG);
    assign core_a         = rf_a;
    assign core_b         = rf_b;
    assign dbg_rdata      = rf_a;
    assign arb_state      = state_q;

endmodule

// File: tb/tb_riscv_regfile_arbiter.sv
// Directed bench for riscv_regfile_arbiter with a behavioural registered-read register file.
module tb_riscv_regfile_arbiter;

  localparam logic ST_SHARED = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        core_req = 1'b0, core_wen = 1'b0;
  logic [4:0]  core_ra = '0, core_rb = '0, core_rd = '0;
  logic [31:0] core_wdata = '0;
  logic        core_ready, core_rsp_valid;
  logic [31:0] core_a, core_b;
  logic        dbg_req = 1'b0, dbg_wen = 1'b0, dbg_lock = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ready, dbg_rsp_valid;
  logic [31:0] dbg_rdata;
  logic        rf_cs, rf_wen;
  logic [4:0]  rf_ra, rf_rb, rf_rd;
  logic [31:0] rf_data;
  logic [31:0] rf_a = '0, rf_b = '0;
  logic        arb_state;
  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  riscv_regfile_arbiter #(.DBG_MAX_WAIT(8)) dut (
    .clk(clk), .rstn(rstn),
    .core_req(core_req), .core_ready(core_ready),
    .core_ra(core_ra), .core_rb(core_rb), .core_rd(core_rd),
    .core_wen(core_wen), .core_wdata(core_wdata),
    .core_rsp_valid(core_rsp_valid), .core_a(core_a), .core_b(core_b),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
    .dbg_wen(dbg_wen), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rdata(dbg_rdata),
    .rf_cs(rf_cs), .rf_wen(rf_wen), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rd(rf_rd),
    .rf_data(rf_data), .rf_a(rf_a), .rf_b(rf_b),
    .arb_state(arb_state)
  );

  // register file model: registered read ports, old value on read-during-write, x0 not hardwired
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  end

  always @(posedge clk) begin
    if (rf_cs) begin
      rf_a <= mem[rf_ra];
      rf_b <= mem[rf_rb];
      if (rf_wen) mem[rf_rd] <= rf_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: called right after a falling edge, outputs are sampled #1 later
  task automatic idle();
    core_req = 1'b0; core_wen = 1'b0; core_ra = '0; core_rb = '0; core_rd = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 1'b0;
  endtask

  task automatic drive_core(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                            input logic wen, input logic [31:0] wdata);
    core_req = 1'b1; core_ra = ra; core_rb = rb; core_rd = rd; core_wen = wen; core_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic [4:0] addr, input logic wen, input logic [31:0] wdata,
                           input logic lock);
    dbg_req = 1'b1; dbg_addr = addr; dbg_wen = wen; dbg_wdata = wdata; dbg_lock = lock;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    // reset state, with a core request present to show the forced-low readies
    core_req = 1'b1;
    #1;
    check("rst_core_ready", 32'(core_ready), 32'd0);
    check("rst_rf_cs", 32'(rf_cs), 32'd0);
    check("rst_core_rsp", 32'(core_rsp_valid), 32'd0);
    check("rst_dbg_rsp", 32'(dbg_rsp_valid), 32'd0);
    check("rst_state", 32'(arb_state), 32'(ST_SHARED));
    @(negedge clk); @(negedge clk);
    idle();
    rstn = 1'b1;

    // core write x5 then read ra=5 rb=0
    next_cycle(); drive_core(5'd0, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF); #1;
    check("wr5_ready", 32'(core_ready), 32'd1);
    check("wr5_rf_wen", 32'(rf_wen), 32'd1);
    check("wr5_rf_rd", 32'(rf_rd), 32'd5);
    check("wr5_rf_data", rf_data, 32'hDEADBEEF);
    next_cycle(); drive_core(5'd5, 5'd0, 5'd0, 1'b0, 32'd0); #1;
    check("wr5_rsp", 32'(core_rsp_valid), 32'd1);
    next_cycle(); #1;
    check("rd5_rsp", 32'(core_rsp_valid), 32'd1);
    check("rd5_a", core_a, 32'hDEADBEEF);
    check("rd5_b", core_b, 32'd0);
    next_cycle(); #1;
    check("rsp_one_cycle", 32'(core_rsp_valid), 32'd0);

    // x0 protection
    next_cycle(); drive_core(5'd0, 5'd0, 5'd0, 1'b1, 32'h12345678); #1;
    check("x0_core_cs", 32'(rf_cs), 32'd1);
    check("x0_core_wen", 32'(rf_wen), 32'd0);
    next_cycle(); drive_dbg(5'd0, 1'b1, 32'h12345678, 1'b0); #1;
    check("x0_dbg_ready", 32'(dbg_ready), 32'd1);
    check("x0_dbg_wen", 32'(rf_wen), 32'd0);
    next_cycle(); drive_dbg(5'd0, 1'b0, 32'd0, 1'b0); #1;
    check("x0_dbg_rsp_wr", 32'(dbg_rsp_valid), 32'd1);
    next_cycle(); #1;
    check("x0_dbg_rsp_rd", 32'(dbg_rsp_valid), 32'd1);
    check("x0_dbg_rdata", dbg_rdata, 32'd0);

    // starvation bound: debug first granted in cycle 8, response in cycle 9
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      drive_core(5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      if (c < 9) drive_dbg(5'd5, 1'b0, 32'd0, 1'b0);
      #1;
      check($sformatf("starve_dbg_ready_c%0d", c), 32'(dbg_ready), 32'(c == 8));
      check($sformatf("starve_core_ready_c%0d", c), 32'(core_ready), 32'(c != 8));
      check($sformatf("starve_dbg_rsp_c%0d", c), 32'(dbg_rsp_valid), 32'(c == 9));
    end
    check("starve_dbg_rdata", dbg_rdata, 32'hDEADBEEF);

    // debug lock: core blocked while locked, granted in the cycle the lock falls
    next_cycle(); drive_dbg(5'd1, 1'b0, 32'd0, 1'b1); #1;
    check("lock_grant", 32'(dbg_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive_core(5'd2, 5'd3, 5'd0, 1'b0, 32'd0);
      dbg_lock = 1'b1;
      dbg_req = 1'(i % 2);
      #1;
      check($sformatf("lock_core_ready_%0d", i), 32'(core_ready), 32'd0);
      check($sformatf("lock_dbg_ready_%0d", i), 32'(dbg_ready), 32'(i % 2));
      check($sformatf("lock_state_%0d", i), 32'(arb_state), 32'(ST_LOCKED));
    end
    next_cycle(); drive_core(5'd2, 5'd3, 5'd0, 1'b0, 32'd0); #1;
    check("unlock_core_ready", 32'(core_ready), 32'd1);
    next_cycle(); #1;
    check("unlock_state", 32'(arb_state), 32'(ST_SHARED));

    // read-during-write returns the old value
    next_cycle(); drive_core(5'd0, 5'd0, 5'd7, 1'b1, 32'd1);
    next_cycle(); drive_core(5'd7, 5'd5, 5'd7, 1'b1, 32'd2);
    next_cycle(); drive_core(5'd7, 5'd0, 5'd0, 1'b0, 32'd0); #1;
    check("rdw_old_a", core_a, 32'd1);
    check("rdw_b", core_b, 32'hDEADBEEF);
    next_cycle(); #1;
    check("rdw_new_a", core_a, 32'd2);

    // async reset mid-lock with a pending debug response
    next_cycle(); drive_dbg(5'd5, 1'b0, 32'd0, 1'b1);
    @(posedge clk); #2;
    check("prerst_dbg_rsp", 32'(dbg_rsp_valid), 32'd1);
    core_req = 1'b1;
    rstn = 1'b0; #1;
    check("midrst_dbg_rsp", 32'(dbg_rsp_valid), 32'd0);
    check("midrst_dbg_ready", 32'(dbg_ready), 32'd0);
    check("midrst_core_ready", 32'(core_ready), 32'd0);
    check("midrst_rf_cs", 32'(rf_cs), 32'd0);
    check("midrst_state", 32'(arb_state), 32'(ST_SHARED));
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    idle();
    drive_core(5'd5, 5'd0, 5'd0, 1'b0, 32'd0);
    drive_dbg(5'd5, 1'b0, 32'd0, 1'b1); #1;
    check("postrst_core_ready", 32'(core_ready), 32'd1);
    check("postrst_dbg_ready", 32'(dbg_ready), 32'd0);
    check("postrst_dbg_rsp", 32'(dbg_rsp_valid), 32'd0);
    next_cycle(); #1;
    check("postrst_core_rsp", 32'(core_rsp_valid), 32'd1);
    check("postrst_no_dbg_rsp", 32'(dbg_rsp_valid), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
